// File: rtl/sad_pkg.sv
// Shared definitions for the SAD engine: control states, accumulator width
// helper and an elaboration-time parameter legality check.
package sad_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sad_state_e;

    // Accumulator width that holds BLOCK_N * (2**DATA_W - 1) without overflow.
    function automatic int acc_width(input int data_w, input int block_n);
        return data_w + $clog2(block_n + 1);
    endfunction

endpackage

// Elaboration check: LANES a power of two in 1..16, BLOCK_N a multiple of LANES.
`define SAD_CHECK_PARAMS(BN, LN) \
    if ((((BN) % (LN)) != 0) || ((BN) < (LN)) || ((LN) < 1) || ((LN) > 16) || \
        (((LN) & ((LN) - 1)) != 0)) begin : g_bad_params \
        $error("sad_engine: illegal BLOCK_N/LANES combination"); \
    end

// File: rtl/sad_absdiff_tree.sv
// Combinational per-lane |a - b| followed by a reduction over all lanes.
// The result is wide enough that the lane sum can never overflow.
module sad_absdiff_tree #(
    parameter int  DATA_W = 8,
    parameter int  LANES  = 1,
    localparam int SUM_W  = DATA_W + $clog2(LANES) + 1
) (
    input  logic [LANES*DATA_W-1:0] a_s,
    input  logic [LANES*DATA_W-1:0] b_s,
    output logic [SUM_W-1:0]        sum_s
);

    function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

    logic [SUM_W-1:0] sum_v;

    // Reduce the absolute differences of all lanes into one unsigned sum.
    always_comb begin
        sum_v = {SUM_W{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            sum_v = sum_v + SUM_W'(abs_diff(a_s[k*DATA_W +: DATA_W], b_s[k*DATA_W +: DATA_W]));
        end
        sum_s = sum_v;
    end

endmodule

// File: rtl/sad_engine.sv
// Sum-of-absolute-differences engine: LANES sample pairs per beat, one SAD
// per BLOCK_N pairs. Stage 1 registers the lane sum, stage 2 accumulates.
// Optional minimum tracking is enabled by defining SAD_MINTRACK_EN.
module sad_engine
    import sad_pkg::*;
#(
    parameter int  DATA_W  = 8,
    parameter int  BLOCK_N = 256,
    parameter int  LANES   = 1,
    localparam int ACC_W   = acc_width(DATA_W, BLOCK_N)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enb_i,
    input  logic                    abort_i,
    input  logic                    vld_i,
    output logic                    rdy_o,
    input  logic [LANES*DATA_W-1:0] dta_i,
    input  logic [LANES*DATA_W-1:0] dtb_i,
`ifdef SAD_MINTRACK_EN
    input  logic                    clr_min_i,
    output logic [ACC_W-1:0]        min_o,
    output logic [15:0]             min_idx_o,
`endif
    output logic [ACC_W-1:0]        dt_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int SUM_W = DATA_W + $clog2(LANES) + 1;
    localparam int CNT_W = $clog2(BLOCK_N + 1);

    `SAD_CHECK_PARAMS(BLOCK_N, LANES)

    sad_state_e       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [SUM_W-1:0] lane_sum_s, s1_sum_r;
    logic             s1_vld_r, s1_last_r;
    logic [ACC_W-1:0] acc_r, dt_r;
    logic             acc_last_r;
    logic             rdy_r, busy_r, done_r;
    logic             start_s, beat_s, last_beat_s, fin_s;

    sad_absdiff_tree #(.DATA_W(DATA_W), .LANES(LANES)) u_tree (
        .a_s   (dta_i),
        .b_s   (dtb_i),
        .sum_s (lane_sum_s)
    );

    // Abort overrides every event; beats are only taken while ready is asserted.
    assign start_s     = (state_r == IDLE) && enb_i && !abort_i;
    assign beat_s      = (state_r == RUN) && vld_i && rdy_r && !abort_i;
    assign last_beat_s = beat_s && (cnt_r == CNT_W'(BLOCK_N - LANES));
    assign fin_s       = (state_r == DRAIN) && acc_last_r && !abort_i;

    // Next-state logic: abort returns to IDLE from anywhere.
    always_comb begin
        state_nxt_s = state_r;
        if (abort_i) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    if (enb_i) state_nxt_s = RUN; else state_nxt_s = IDLE;
                RUN:     if (last_beat_s) state_nxt_s = DRAIN; else state_nxt_s = RUN;
                DRAIN:   if (fin_s) state_nxt_s = DONE; else state_nxt_s = DRAIN;
                DONE:    state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered handshake/status flags; ready opens one cycle after entering RUN.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdy_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            rdy_r  <= (state_r == RUN) && (state_nxt_s == RUN);
            busy_r <= (state_nxt_s == RUN) || (state_nxt_s == DRAIN);
            done_r <= (state_nxt_s == DONE);
        end
    end

    // Beat counter and stage-1 lane-sum register with its valid/last flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_r     <= {CNT_W{1'b0}};
            s1_sum_r  <= {SUM_W{1'b0}};
            s1_vld_r  <= 1'b0;
            s1_last_r <= 1'b0;
        end else begin
            if (start_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (beat_s) begin
                cnt_r <= cnt_r + CNT_W'(LANES);
            end else begin
                cnt_r <= cnt_r;
            end
            if (beat_s) begin
                s1_sum_r <= lane_sum_s;
            end else begin
                s1_sum_r <= s1_sum_r;
            end
            s1_vld_r  <= beat_s;
            s1_last_r <= last_beat_s;
        end
    end

    // Stage-2 accumulator; the final value is published one cycle after it settles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc_r      <= {ACC_W{1'b0}};
            acc_last_r <= 1'b0;
            dt_r       <= {ACC_W{1'b0}};
        end else begin
            if (start_s) begin
                acc_r <= {ACC_W{1'b0}};
            end else if (s1_vld_r && !abort_i) begin
                acc_r <= acc_r + ACC_W'(s1_sum_r);
            end else begin
                acc_r <= acc_r;
            end
            acc_last_r <= s1_vld_r && s1_last_r && !abort_i;
            if (fin_s) begin
                dt_r <= acc_r;
            end else begin
                dt_r <= dt_r;
            end
        end
    end

    assign rdy_o  = rdy_r;
    assign busy_o = busy_r;
    assign done_o = done_r;
    assign dt_o   = dt_r;

`ifdef SAD_MINTRACK_EN
    logic [ACC_W-1:0] min_r;
    logic [15:0]      min_idx_r, blk_idx_r;

    // Track the smallest SAD seen; strict less-than keeps the earliest on ties.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            min_r     <= {ACC_W{1'b1}};
            min_idx_r <= 16'd0;
            blk_idx_r <= 16'd0;
        end else if (clr_min_i) begin
            min_r     <= {ACC_W{1'b1}};
            min_idx_r <= 16'd0;
            blk_idx_r <= 16'd0;
        end else if (fin_s) begin
            blk_idx_r <= blk_idx_r + 16'd1;
            if (acc_r < min_r) begin
                min_r     <= acc_r;
                min_idx_r <= blk_idx_r;
            end else begin
                min_r     <= min_r;
                min_idx_r <= min_idx_r;
            end
        end else begin
            min_r     <= min_r;
            min_idx_r <= min_idx_r;
            blk_idx_r <= blk_idx_r;
        end
    end

    assign min_o     = min_r;
    assign min_idx_o = min_idx_r;
`endif

endmodule

// File: tb/tb_sad_engine.sv
// Directed bench for sad_engine: instance A (DATA_W=8, BLOCK_N=16, LANES=4)
// and instance B (DATA_W=8, BLOCK_N=256, LANES=1).
module tb_sad_engine;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance A signals
    logic        enb_a, abort_a, vld_a, rdy_a, busy_a, done_a;
    logic [31:0] dta_a, dtb_a;
    logic [12:0] dt_a;
    // Instance B signals
    logic        enb_b, abort_b, vld_b, rdy_b, busy_b, done_b;
    logic [7:0]  dta_b, dtb_b;
    logic [16:0] dt_b;
`ifdef SAD_MINTRACK_EN
    logic        clr_a, clr_b;
    logic [12:0] min_a;
    logic [16:0] min_b;
    logic [15:0] idx_a, idx_b;
`endif

    sad_engine #(.DATA_W(8), .BLOCK_N(16), .LANES(4)) u_dut_a (
        .clk_i(clk), .rst_i(rst_n), .enb_i(enb_a), .abort_i(abort_a),
        .vld_i(vld_a), .rdy_o(rdy_a), .dta_i(dta_a), .dtb_i(dtb_a),
`ifdef SAD_MINTRACK_EN
        .clr_min_i(clr_a), .min_o(min_a), .min_idx_o(idx_a),
`endif
        .dt_o(dt_a), .busy_o(busy_a), .done_o(done_a)
    );

    sad_engine #(.DATA_W(8), .BLOCK_N(256), .LANES(1)) u_dut_b (
        .clk_i(clk), .rst_i(rst_n), .enb_i(enb_b), .abort_i(abort_b),
        .vld_i(vld_b), .rdy_o(rdy_b), .dta_i(dta_b), .dtb_i(dtb_b),
`ifdef SAD_MINTRACK_EN
        .clr_min_i(clr_b), .min_o(min_b), .min_idx_o(idx_b),
`endif
        .dt_o(dt_b), .busy_o(busy_b), .done_o(done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one block on instance A with constant beat data; optional abort after N beats.
    task automatic run_a(input logic [31:0] av, input logic [31:0] bv, input int abort_after,
                         output int hs, output int lat, output int busy_cyc, output int dones);
        int  last;
        bit  ab;
        hs = 0; lat = -1; busy_cyc = 0; dones = 0; last = 0; ab = 1'b0;
        dta_a = av; dtb_a = bv; enb_a = 1'b1; vld_a = 1'b1;
        tick();
        enb_a = 1'b0;
        if (busy_a) busy_cyc++;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (vld_a && rdy_a) begin
                hs++;
                last = cyc;
            end
            tick();
            abort_a = 1'b0;
            if (busy_a) busy_cyc++;
            if (done_a) begin
                dones++;
                lat = (cyc + 1) - last;
                break;
            end
            if (hs >= 4) vld_a = 1'b0;
            if (abort_after > 0 && hs == abort_after && !ab) begin
                abort_a = 1'b1;
                vld_a   = 1'b0;
                ab      = 1'b1;
            end
        end
        vld_a = 1'b0;
        abort_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enb_a = 1'b0; abort_a = 1'b0; vld_a = 1'b0; dta_a = 32'd0; dtb_a = 32'd0;
        enb_b = 1'b0; abort_b = 1'b0; vld_b = 1'b0; dta_b = 8'd0; dtb_b = 8'd0;
`ifdef SAD_MINTRACK_EN
        clr_a = 1'b0; clr_b = 1'b0;
`endif
        tick(); tick();
        n_cmp++; if (rdy_a !== 1'b0) begin n_bad++; $display("FAIL reset_rdy: got %b want 0", rdy_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done_a); end
        n_cmp++; if (dt_a !== 13'd0) begin n_bad++; $display("FAIL reset_dt: got %0d want 0", dt_a); end
        n_cmp++; if (dt_b !== 17'd0) begin n_bad++; $display("FAIL reset_dt_b: got %0d want 0", dt_b); end
`ifdef SAD_MINTRACK_EN
        n_cmp++; if (min_a !== 13'h1FFF) begin n_bad++; $display("FAIL reset_min: got %0h want 1fff", min_a); end
        n_cmp++; if (idx_a !== 16'd0) begin n_bad++; $display("FAIL reset_min_idx: got %0d want 0", idx_a); end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_max();
        int hs, lat, bc, dn;
        run_a(32'hFFFF_FFFF, 32'h0000_0000, 0, hs, lat, bc, dn);
        n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL max_done: got %0d pulses want 1", dn); end
        n_cmp++; if (dt_a !== 13'd4080) begin n_bad++; $display("FAIL max_dt: got %0d want 4080", dt_a); end
        n_cmp++; if (hs !== 4) begin n_bad++; $display("FAIL max_beats: got %0d want 4", hs); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL max_latency: got %0d want 3", lat); end
        n_cmp++; if (bc !== 7) begin n_bad++; $display("FAIL max_busy_cycles: got %0d want 7", bc); end
        tick();
        n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL done_width: got %b want 0", done_a); end
        n_cmp++; if (dt_a !== 13'd4080) begin n_bad++; $display("FAIL dt_hold: got %0d want 4080", dt_a); end
    endtask

    task automatic test_patterns();
        int hs, lat, bc, dn;
        run_a(32'h5A5A_5A5A, 32'h5A5A_5A5A, 0, hs, lat, bc, dn);
        n_cmp++; if (dt_a !== 13'd0) begin n_bad++; $display("FAIL equal_dt: got %0d want 0", dt_a); end
        tick();
        run_a(32'h1010_1010, 32'h3030_3030, 0, hs, lat, bc, dn);
        n_cmp++; if (dt_a !== 13'd512) begin n_bad++; $display("FAIL neg_dt: got %0d want 512", dt_a); end
        tick();
        run_a(32'h3030_3030, 32'h1010_1010, 0, hs, lat, bc, dn);
        n_cmp++; if (dn !== 1 || dt_a !== 13'd512) begin n_bad++; $display("FAIL pos_dt: got %0d (pulses %0d) want 512 (1)", dt_a, dn); end
        tick();
    endtask

    task automatic test_abort();
        int hs, lat, bc, dn;
        run_a(32'hFFFF_FFFF, 32'h0000_0000, 0, hs, lat, bc, dn);
        n_cmp++; if (dt_a !== 13'd4080) begin n_bad++; $display("FAIL pre_abort_dt: got %0d want 4080", dt_a); end
        tick();
        run_a(32'h1010_1010, 32'h3030_3030, 2, hs, lat, bc, dn);
        n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dn); end
        n_cmp++; if (dt_a !== 13'd4080) begin n_bad++; $display("FAIL abort_dt_kept: got %0d want 4080", dt_a); end
        n_cmp++; if (busy_a !== 1'b0 || rdy_a !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got busy %b rdy %b want 0 0", busy_a, rdy_a); end
        run_a(32'h2020_2020, 32'h2828_2828, 0, hs, lat, bc, dn);
        n_cmp++; if (dt_a !== 13'd128) begin n_bad++; $display("FAIL post_abort_dt: got %0d want 128", dt_a); end
        tick();
    endtask

    task automatic test_hold_enb();
        int hs_since, dones;
        hs_since = 0; dones = 0;
        dta_a = 32'h0303_0303; dtb_a = 32'h0000_0000;
        enb_a = 1'b1; vld_a = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (vld_a && rdy_a) hs_since++;
            tick();
            if (done_a) begin
                dones++;
                n_cmp++; if (hs_since !== 4 || dt_a !== 13'd48) begin n_bad++; $display("FAIL hold_block: got %0d beats dt %0d want 4 beats dt 48", hs_since, dt_a); end
                hs_since = 0;
            end
        end
        n_cmp++; if (dones !== 3) begin n_bad++; $display("FAIL hold_blocks: got %0d want 3", dones); end
        enb_a = 1'b0; vld_a = 1'b0; abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_run();
        dta_a = 32'h1010_1010; dtb_a = 32'h3030_3030; enb_a = 1'b1; vld_a = 1'b1;
        tick();
        enb_a = 1'b0;
        tick(); tick();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (busy_a !== 1'b0 || rdy_a !== 1'b0 || done_a !== 1'b0 || dt_a !== 13'd0) begin
            n_bad++; $display("FAIL async_reset: got busy %b rdy %b done %b dt %0d want all 0", busy_a, rdy_a, done_a, dt_a);
        end
        vld_a = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lanes1_random();
        logic [7:0] va [256];
        logic [7:0] vb [256];
        int ref_sum, idx, hs, rdy_bad, last, lat;
        bit seen;
        ref_sum = 0; idx = 0; hs = 0; rdy_bad = 0; last = 0; lat = -1; seen = 1'b0;
        for (int i = 0; i < 256; i++) begin
            va[i] = 8'($urandom_range(0, 255));
            vb[i] = 8'($urandom_range(0, 255));
            ref_sum += (va[i] > vb[i]) ? (int'(va[i]) - int'(vb[i])) : (int'(vb[i]) - int'(va[i]));
        end
        enb_b = 1'b1;
        tick();
        enb_b = 1'b0;
        vld_b = 1'($urandom_range(0, 1)); dta_b = va[0]; dtb_b = vb[0];
        for (int cyc = 1; cyc < 2000; cyc++) begin
            if (vld_b && rdy_b) begin
                hs++; idx++; last = cyc;
            end
            tick();
            if (done_b) begin
                seen = 1'b1;
                lat = (cyc + 1) - last;
                break;
            end
            if (hs == 256 && rdy_b) rdy_bad++;
            if (idx < 256) begin
                vld_b = 1'($urandom_range(0, 1)); dta_b = va[idx]; dtb_b = vb[idx];
            end else begin
                vld_b = 1'b0;
            end
        end
        vld_b = 1'b0;
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL l1_done_timeout: got no done want done"); end
        n_cmp++; if (hs !== 256) begin n_bad++; $display("FAIL l1_beats: got %0d want 256", hs); end
        n_cmp++; if (dt_b !== 17'(ref_sum)) begin n_bad++; $display("FAIL l1_dt: got %0d want %0d", dt_b, ref_sum); end
        n_cmp++; if (rdy_bad !== 0) begin n_bad++; $display("FAIL l1_rdy_drain: got %0d ready cycles want 0", rdy_bad); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL l1_latency: got %0d want 3", lat); end
        tick();
    endtask

`ifdef SAD_MINTRACK_EN
    task automatic test_mintrack();
        int hs, lat, bc, dn;
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        n_cmp++; if (min_a !== 13'h1FFF || idx_a !== 16'd0) begin n_bad++; $display("FAIL min_clr0: got %0h/%0d want 1fff/0", min_a, idx_a); end
        run_a(32'd75, 32'd0, 0, hs, lat, bc, dn);  tick();
        run_a(32'd30, 32'd0, 0, hs, lat, bc, dn);  tick();
        run_a(32'd30, 32'd0, 0, hs, lat, bc, dn);  tick();
        run_a(32'd125, 32'd0, 0, hs, lat, bc, dn);
        n_cmp++; if (dt_a !== 13'd500) begin n_bad++; $display("FAIL min_last_dt: got %0d want 500", dt_a); end
        tick();
        n_cmp++; if (min_a !== 13'd120) begin n_bad++; $display("FAIL min_value: got %0d want 120", min_a); end
        n_cmp++; if (idx_a !== 16'd1) begin n_bad++; $display("FAIL min_index: got %0d want 1", idx_a); end
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        n_cmp++; if (min_a !== 13'h1FFF || idx_a !== 16'd0) begin n_bad++; $display("FAIL min_clr: got %0h/%0d want 1fff/0", min_a, idx_a); end
    endtask
`endif

    initial begin
        test_reset();
        test_max();
        test_patterns();
        test_abort();
        test_hold_enb();
`ifdef SAD_MINTRACK_EN
        test_mintrack();
`endif
        test_lanes1_random();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
